// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared constants, slot state and width helper for seg7 display blocks
//
// Purpose: segment patterns (gfedcba, active-high), the scan slot state
// enum and a ceiling-log2 helper used to size the phase and digit counters.
// Ports: none (package).

package seg7_pkg;

   localparam logic [6:0] SEG_0    = 7'h3F;
   localparam logic [6:0] SEG_1    = 7'h06;
   localparam logic [6:0] SEG_2    = 7'h5B;
   localparam logic [6:0] SEG_3    = 7'h4F;
   localparam logic [6:0] SEG_4    = 7'h66;
   localparam logic [6:0] SEG_5    = 7'h6D;
   localparam logic [6:0] SEG_6    = 7'h7D;
   localparam logic [6:0] SEG_7    = 7'h07;
   localparam logic [6:0] SEG_8    = 7'h7F;
   localparam logic [6:0] SEG_9    = 7'h6F;
   localparam logic [6:0] SEG_DASH = 7'h40;
   localparam logic [6:0] SEG_OFF  = 7'h00;

   typedef enum logic {
      ST_BLANK,
      ST_SHOW
   } slot_state_t;

   // Never returns less than 1 so a single-value counter still has a bit.
   function automatic int clog2(input int value);
      int w;
      w = 1;
      while ((1 << w) < value) begin
         w = w + 1;
      end
      return w;
   endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// rtl/bcd_to_seg7.sv - combinational BCD to seven-segment decoder with blank override
//
// Purpose: maps a 4-bit code to segments {g,f,e,d,c,b,a}; codes A..F show a dash.
// Ports:
//   code  in  4  BCD code
//   blank in  1  forces all segments off
//   seg   out 7  segment pattern, active-high

module bcd_to_seg7
   import seg7_pkg::*;
(
   input  logic [3:0] code,
   input  logic       blank,
   output logic [6:0] seg
);

   always_comb begin
      seg = SEG_OFF;
      if (!blank) begin
         case (code)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_DASH;
         endcase
      end
   end

endmodule

// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - tear-free multiplexed seven-segment scan driver
//
// Purpose: snapshots a packed BCD value into a shadow register, promotes it to
// the display register only at a frame boundary, and scans one digit per slot
// with leading dead-time, leading-zero blanking and dash for invalid codes.
// Ports:
//   clk      in  1         clock, rising edge
//   rst_n    in  1         asynchronous active-low reset
//   bcd_in   in  4*DIGITS  packed BCD, digit i at [4i+3:4i]
//   dp_in    in  DIGITS    decimal-point request per digit
//   load     in  1         capture strobe for bcd_in/dp_in
//   lzb_en   in  1         leading-zero blanking enable
//   seg      out 7         segments {g,f,e,d,c,b,a}, registered
//   dp       out 1         decimal point, registered
//   an       out DIGITS    one-hot digit enable, registered
//   frame_tc out 1         high in the last cycle of each frame

module seg7_scan_driver
   import seg7_pkg::*;
#(
   parameter int DIGITS    = 4,
   parameter int SCAN_DIV  = 1000,
   parameter int BLANK_CYC = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [4*DIGITS-1:0]   bcd_in,
   input  logic [DIGITS-1:0]     dp_in,
   input  logic                  load,
   input  logic                  lzb_en,
   output logic [6:0]            seg,
   output logic                  dp,
   output logic [DIGITS-1:0]     an,
   output logic                  frame_tc
);

   localparam int PW = clog2(SCAN_DIV);
   localparam int DW = clog2(DIGITS);
   localparam logic [PW-1:0] P_LAST  = PW'(SCAN_DIV - 1);
   localparam logic [PW-1:0] P_BLANK = PW'(BLANK_CYC);
   localparam logic [DW-1:0] D_LAST  = DW'(DIGITS - 1);
   localparam slot_state_t   ST_INIT = (BLANK_CYC == 0) ? ST_SHOW : ST_BLANK;

   logic [4*DIGITS-1:0] shadow_bcd, disp_bcd, disp_bcd_nxt;
   logic [DIGITS-1:0]   shadow_dp, disp_dp, disp_dp_nxt;
   logic                pend, pend_nxt;
   logic [PW-1:0]       p, p_nxt;
   logic [DW-1:0]       d, d_nxt;
   slot_state_t         st, st_nxt;
   logic                frame_end;

   logic [DIGITS-1:0]   blank_vec;
   logic [DIGITS-1:0]   an_nxt;
   logic [3:0]          dig_code;
   logic                dig_dp, dig_blank, show;
   logic [6:0]          dig_seg;

   assign frame_end = (d == D_LAST) && (p == P_LAST);
   assign frame_tc  = frame_end;
   assign p_nxt     = (p == P_LAST) ? '0 : p + 1'b1;
   assign d_nxt     = (p != P_LAST) ? d : ((d == D_LAST) ? '0 : d + 1'b1);

   // Slot FSM: dead-time first, then show; BLANK_CYC=0 never leaves SHOW.
   always_comb begin
      st_nxt = st;
      case (st)
         ST_BLANK: if (p_nxt == P_BLANK) st_nxt = ST_SHOW;
         ST_SHOW:  if ((p == P_LAST) && (P_BLANK != '0)) st_nxt = ST_BLANK;
         default:  st_nxt = ST_INIT;
      endcase
   end

   // A load in the boundary cycle itself bypasses the shadow so it is not lost.
   always_comb begin
      disp_bcd_nxt = disp_bcd;
      disp_dp_nxt  = disp_dp;
      pend_nxt     = pend | load;
      if (frame_end) begin
         pend_nxt = 1'b0;
         if (load) begin
            disp_bcd_nxt = bcd_in;
            disp_dp_nxt  = dp_in;
         end else if (pend) begin
            disp_bcd_nxt = shadow_bcd;
            disp_dp_nxt  = shadow_dp;
         end
      end
   end

   // Outputs are computed from next-cycle counters and display so the
   // registered outputs line up with p/d with no extra latency.
   always_comb begin
      logic all_zero;
      all_zero  = 1'b1;
      blank_vec = '0;
      for (int i = DIGITS - 1; i >= 0; i--) begin
         all_zero = all_zero && (disp_bcd_nxt[4*i +: 4] == 4'd0);
         if (lzb_en && (i != 0) && all_zero && !disp_dp_nxt[i]) begin
            blank_vec[i] = 1'b1;
         end
      end

      show      = (st_nxt == ST_SHOW);
      dig_code  = 4'd0;
      dig_dp    = 1'b0;
      dig_blank = 1'b0;
      an_nxt    = '0;
      for (int i = 0; i < DIGITS; i++) begin
         if (d_nxt == DW'(i)) begin
            dig_code  = disp_bcd_nxt[4*i +: 4];
            dig_dp    = disp_dp_nxt[i];
            dig_blank = blank_vec[i];
            an_nxt[i] = show;
         end
      end
   end

   bcd_to_seg7 u_dec (
      .code  (dig_code),
      .blank (dig_blank | ~show),
      .seg   (dig_seg)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shadow_bcd <= '0;
         shadow_dp  <= '0;
         pend       <= 1'b0;
         disp_bcd   <= '0;
         disp_dp    <= '0;
         p          <= '0;
         d          <= '0;
         st         <= ST_INIT;
         seg        <= SEG_OFF;
         dp         <= 1'b0;
         an         <= '0;
      end else begin
         if (load) begin
            shadow_bcd <= bcd_in;
            shadow_dp  <= dp_in;
         end
         pend     <= pend_nxt;
         disp_bcd <= disp_bcd_nxt;
         disp_dp  <= disp_dp_nxt;
         p        <= p_nxt;
         d        <= d_nxt;
         st       <= st_nxt;
         seg      <= dig_seg;
         dp       <= show & dig_dp & ~dig_blank;
         an       <= an_nxt;
      end
   end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb/tb_seg7_scan_driver.sv - directed self-checking bench for seg7_scan_driver

module tb_seg7_scan_driver;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] bcd_in;
   logic [3:0]  dp_in;
   logic        load;
   logic        lzb_en;
   logic [6:0]  seg;
   logic        dp;
   logic [3:0]  an;
   logic        frame_tc;

   int n_cmp  = 0;
   int n_fail = 0;
   int tb_p   = 0;
   int tb_d   = 0;

   seg7_scan_driver #(.DIGITS(4), .SCAN_DIV(8), .BLANK_CYC(2)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .bcd_in   (bcd_in),
      .dp_in    (dp_in),
      .load     (load),
      .lzb_en   (lzb_en),
      .seg      (seg),
      .dp       (dp),
      .an       (an),
      .frame_tc (frame_tc)
   );

   always #5 clk = ~clk;

   function automatic logic [6:0] exp_seg(input logic [3:0] c);
      case (c)
         4'd0: return 7'h3F;  4'd1: return 7'h06;  4'd2: return 7'h5B;
         4'd3: return 7'h4F;  4'd4: return 7'h66;  4'd5: return 7'h6D;
         4'd6: return 7'h7D;  4'd7: return 7'h07;  4'd8: return 7'h7F;
         4'd9: return 7'h6F;  default: return 7'h40;
      endcase
   endfunction

   // One clock; bench-side position follows the scan independently of the DUT.
   task automatic tick();
      @(posedge clk);
      #1;
      if (tb_p == 7) begin
         tb_p = 0;
         tb_d = (tb_d == 3) ? 0 : tb_d + 1;
      end else begin
         tb_p = tb_p + 1;
      end
   endtask

   task automatic run_to(input int dd, input int pp);
      int guard;
      guard = 0;
      do begin
         tick();
         guard++;
      end while (!(tb_d == dd && tb_p == pp) && guard < 100);
   endtask

   task automatic load_value(input logic [15:0] v, input logic [3:0] dpv);
      bcd_in = v;
      dp_in  = dpv;
      load   = 1'b1;
      tick();
      load   = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; load = 1'b0; bcd_in = '0; dp_in = '0; lzb_en = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      n_cmp++;
      if ({an, seg, dp, frame_tc} !== 13'h0) begin
         n_fail++;
         $display("FAIL reset_hold got=%h exp=%h", {an, seg, dp, frame_tc}, 13'h0);
      end
      rst_n = 1'b1;
      tb_p = 0; tb_d = 0;
      #1;
      n_cmp++;
      if ({an, seg, dp, frame_tc} !== 13'h0) begin
         n_fail++;
         $display("FAIL reset_release got=%h exp=%h", {an, seg, dp, frame_tc}, 13'h0);
      end
   endtask

   task automatic test_scan();
      logic [15:0] v;
      logic [12:0] exp;
      logic [3:0]  code;
      v = 16'h1234;
      load_value(v, 4'b0000);
      for (int n = 0; n < 63; n++) begin
         code = (n < 31) ? 4'd0 : v[4*tb_d +: 4];
         if (tb_p < 2) exp = {4'b0, 7'h00, 1'b0, 1'b0};
         else          exp = {4'(1 << tb_d), exp_seg(code), 1'b0, (tb_d == 3 && tb_p == 7)};
         n_cmp++;
         if ({an, seg, dp, frame_tc} !== exp) begin
            n_fail++;
            $display("FAIL scan n=%0d d=%0d p=%0d got=%h exp=%h", n, tb_d, tb_p,
                     {an, seg, dp, frame_tc}, exp);
         end
         tick();
      end
   endtask

   task automatic test_lzb();
      logic [6:0] es [4];
      es = '{7'h6D, 7'h3F, 7'h66, 7'h00};
      load_value(16'h0405, 4'b0000);
      lzb_en = 1'b1;
      run_to(0, 0);
      for (int i = 0; i < 4; i++) begin
         run_to(i, 2);
         n_cmp++;
         if ({an, seg, dp} !== {4'(1 << i), es[i], 1'b0}) begin
            n_fail++;
            $display("FAIL lzb digit=%0d got=%h exp=%h", i, {an, seg, dp}, {4'(1 << i), es[i], 1'b0});
         end
      end
      lzb_en = 1'b0;
      tick();
      n_cmp++;
      if ({an, seg, dp} !== {4'b1000, 7'h3F, 1'b0}) begin
         n_fail++;
         $display("FAIL lzb_off got=%h exp=%h", {an, seg, dp}, {4'b1000, 7'h3F, 1'b0});
      end
   endtask

   task automatic test_dp_lzb();
      lzb_en = 1'b1;
      load_value(16'h0000, 4'b0100);
      run_to(0, 0);
      run_to(0, 2);
      n_cmp++;
      if ({an, seg, dp} !== {4'b0001, 7'h3F, 1'b0}) begin
         n_fail++;
         $display("FAIL dp_lzb_d0 got=%h exp=%h", {an, seg, dp}, {4'b0001, 7'h3F, 1'b0});
      end
      run_to(2, 2);
      n_cmp++;
      if ({an, seg, dp} !== {4'b0100, 7'h3F, 1'b1}) begin
         n_fail++;
         $display("FAIL dp_lzb_d2 got=%h exp=%h", {an, seg, dp}, {4'b0100, 7'h3F, 1'b1});
      end
      run_to(3, 2);
      n_cmp++;
      if ({an, seg, dp} !== {4'b1000, 7'h00, 1'b0}) begin
         n_fail++;
         $display("FAIL dp_lzb_d3 got=%h exp=%h", {an, seg, dp}, {4'b1000, 7'h00, 1'b0});
      end
   endtask

   task automatic test_dash();
      logic [6:0] es [4];
      es = '{7'h6F, 7'h40, 7'h3F, 7'h40};
      lzb_en = 1'b1;
      load_value(16'hA0F9, 4'b0000);
      run_to(0, 0);
      for (int i = 0; i < 4; i++) begin
         run_to(i, 2);
         n_cmp++;
         if ({an, seg, dp} !== {4'(1 << i), es[i], 1'b0}) begin
            n_fail++;
            $display("FAIL dash digit=%0d got=%h exp=%h", i, {an, seg, dp}, {4'(1 << i), es[i], 1'b0});
         end
      end
      run_to(1, 1);
      n_cmp++;
      if ({an, seg, dp} !== 12'h0) begin
         n_fail++;
         $display("FAIL dash_blank_slot got=%h exp=%h", {an, seg, dp}, 12'h0);
      end
   endtask

   task automatic test_back_to_back();
      logic [12:0] exp;
      lzb_en = 1'b0;
      run_to(1, 3);
      load_value(16'h1111, 4'b0000);
      run_to(2, 2);
      n_cmp++;
      if ({an, seg} !== {4'b0100, 7'h3F}) begin
         n_fail++;
         $display("FAIL tear_keep_old got=%h exp=%h", {an, seg}, {4'b0100, 7'h3F});
      end
      run_to(3, 7);
      n_cmp++;
      if (frame_tc !== 1'b1) begin
         n_fail++;
         $display("FAIL tear_frame_tc got=%b exp=1", frame_tc);
      end
      load_value(16'h2222, 4'b0000);
      for (int n = 0; n < 32; n++) begin
         if (tb_p < 2) exp = 13'h0;
         else          exp = {4'(1 << tb_d), 7'h5B, 1'b0, (tb_d == 3 && tb_p == 7)};
         n_cmp++;
         if ({an, seg, dp, frame_tc} !== exp) begin
            n_fail++;
            $display("FAIL tear_frame d=%0d p=%0d got=%h exp=%h", tb_d, tb_p,
                     {an, seg, dp, frame_tc}, exp);
         end
         tick();
      end
      run_to(2, 4);
      load_value(16'h3333, 4'b0000);
      run_to(3, 2);
      n_cmp++;
      if ({an, seg} !== {4'b1000, 7'h5B}) begin
         n_fail++;
         $display("FAIL midframe_keep got=%h exp=%h", {an, seg}, {4'b1000, 7'h5B});
      end
      run_to(0, 2);
      n_cmp++;
      if ({an, seg} !== {4'b0001, 7'h4F}) begin
         n_fail++;
         $display("FAIL midframe_next got=%h exp=%h", {an, seg}, {4'b0001, 7'h4F});
      end
   endtask

   task automatic test_reset_mid();
      run_to(2, 4);
      load_value(16'h5555, 4'b0000);
      n_cmp++;
      if ({an, seg} !== {4'b0100, 7'h4F}) begin
         n_fail++;
         $display("FAIL pre_reset got=%h exp=%h", {an, seg}, {4'b0100, 7'h4F});
      end
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if ({an, seg, dp, frame_tc} !== 13'h0) begin
         n_fail++;
         $display("FAIL async_reset got=%h exp=%h", {an, seg, dp, frame_tc}, 13'h0);
      end
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      tb_p = 0; tb_d = 0;
      run_to(0, 2);
      n_cmp++;
      if ({an, seg, dp} !== {4'b0001, 7'h3F, 1'b0}) begin
         n_fail++;
         $display("FAIL restart_d0 got=%h exp=%h", {an, seg, dp}, {4'b0001, 7'h3F, 1'b0});
      end
      run_to(0, 2);
      n_cmp++;
      if ({an, seg, dp} !== {4'b0001, 7'h3F, 1'b0}) begin
         n_fail++;
         $display("FAIL pend_lost got=%h exp=%h", {an, seg, dp}, {4'b0001, 7'h3F, 1'b0});
      end
   endtask

   initial begin
      test_reset();
      test_scan();
      test_lzb();
      test_dp_lzb();
      test_dash();
      test_back_to_back();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
